c16_mem_banker: RTL and testbench
=================================

// Module: c16_mem_banker
// PURPOSE
//  Parametrised memory-banking controller for the C16 motherboard. Replaces the fixed 4-bit
//  FDD0-FDDF ROM-select latch with a generalised block, and adds a RAM expansion bank
//  register (Hannes/Csory style, $FD16) with readback, selectable banked window and TED bank policy.
//  Sits on the shared c16_addr/c16_data bus beside the TED.
//  Drives ROM_SEL and the DRAM high-address bits.
// PARAMETERS
//  BANK_BITS    2        RAM expansion bank bits, 0..4 (64K..1M); 0 = expansion absent
//  EXP_WINDOW   0        0 = whole 64K banked; 1 = $0000-$0FFF common (bank 0), $1000-$FFFF banked
//  EXP_ADDR     16'hFD16 address of expansion bank register
//  ROMSEL_BASE  12'hFDD  address[15:4] of ROM-bank latch window
//  KERNAL_PAGE  8'hFC    page that always forces kernal ROM (high select bits 3:2 = 0)
// PORTS
//  CLK28        in   1   system clock, 28 MHz
//  sreset       in   1   synchronous reset, active-high
//  addr         in   16  c16_addr bus
//  data_in      in   8   c16_data bus
//  rw           in   1   1 = read, 0 = write
//  mux          in   1   TED bus-phase signal; rising edge = end of CPU phase
//  aec          in   1   0 = TED owns bus (video fetch), 1 = CPU
//  rom_sel      out  4   [3:2] high ROM slot, [1:0] low ROM slot
//  ram_bank     out  max(BANK_BITS,1)  DRAM bank bits for current access
//  exp_data     out  8   readback onto the AND-ed data bus; 8'hFF when not selected
//  bank_changed out  1   one-CLK28 pulse when the CPU bank value changes
// BEHAVIOUR
//  - Reset (sreset=1): rom_sel_reg=0, cpu_bank=0, ted_follow=0, mux_d=0, bank_changed=0.
//    Outputs after reset: rom_sel=0, ram_bank=0, exp_data=FF.
//  - Capture: every cycle addr_q<=addr, data_q<=data_in, rw_q<=rw, mux_d<=mux.
//  - Write strobe wr_stb = mux & ~mux_d & ~rw_q; uses addr_q/data_q (values one cycle before edge).
//    Exactly one strobe per CPU cycle. mux held high never re-triggers.
//  - ROM latch: on wr_stb with addr_q[15:4]==ROMSEL_BASE: rom_sel_reg<=addr_q[3:0]; data ignored.
//  - rom_sel = {rom_sel_reg[3:2] & ~{2{addr[15:8]==KERNAL_PAGE}}, rom_sel_reg[1:0]}. Combinational on live addr.
//  - Expansion register on wr_stb with addr_q==EXP_ADDR and BANK_BITS>0:
//    cpu_bank<=data_q[BANK_BITS-1:0], ted_follow<=data_q[7]. Data bits between are ignored.
//  - bank_changed=1 for the cycle after a write whose new cpu_bank differs from the old value;
//    same-value rewrite gives no pulse.
//  - Readback: exp_data = (rw & addr==EXP_ADDR & BANK_BITS>0)
//    ? {ted_follow, 1s..., cpu_bank} : 8'hFF. Unimplemented bits read 1.
//  - ram_bank (combinational, registered state only):
//    0 if BANK_BITS==0;
//    0 if aec==0 & ~ted_follow;
//    0 if EXP_WINDOW==1 & addr[15:12]==0;
//    else cpu_bank.
//  - A new bank takes effect from the first cycle after the strobe; the in-flight access is unaffected.
//  - sreset asserted coinciding with wr_stb: reset wins, no write, no pulse.
//  - BANK_BITS==0: the $FD16 write is ignored and exp_data is constantly FF.
// STRUCTURE
//  - Shared include c16_defs.vh: EXP_ADDR, ROMSEL_BASE, KERNAL_PAGE defaults, bus-phase macros.
//  - Sub-module c16_bus_strobe: mux edge detect + addr/data/rw capture, emits wr_stb, addr_q, data_q.
//    Reusable by other motherboard registers.
//  - Top holds rom_sel_reg, cpu_bank, ted_follow, bank_changed and the output decode.
// TESTING
//  1 Reset, then write $FDD6 (data $00) across a mux rising edge -> rom_sel=4'h6.
//    addr=$FC10 -> rom_sel=4'h2. addr=$8000 -> rom_sel=4'h6.
//  2 BANK_BITS=2: write $FD16=$83 -> cpu_bank=3, ted_follow=1, bank_changed pulses once.
//    Read $FD16 -> $FF (bits 6:2 read 1).
//  3 Write $FD16=$03 twice -> bank_changed pulses only on the first.
//    aec=0 -> ram_bank=0 (ted_follow=0); aec=1 -> ram_bank=3.
//  4 EXP_WINDOW=1, bank=2: addr=$0FFF -> ram_bank=0; addr=$1000 -> ram_bank=2.
//  5 Hold mux=1 for 10 cycles with rw=0, addr=$FD16 -> exactly one write.
//    rw=1 at the same address -> no write.
//  6 Assert sreset in the same cycle as wr_stb to $FD16=$01 -> cpu_bank stays 0, no pulse.
//    BANK_BITS=0 build -> exp_data=FF always.

Source files
------------

// File: rtl/c16_mem_banker_pkg.sv
// c16_mem_banker_pkg: shared address defaults, bus capture record and ROM-select decode
package c16_mem_banker_pkg;

    localparam logic [15:0] EXP_ADDR_DEF    = 16'hFD16;
    localparam logic [11:0] ROMSEL_BASE_DEF = 12'hFDD;
    localparam logic [7:0]  KERNAL_PAGE_DEF = 8'hFC;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_cap_t;

    // The kernal page always sees slot 0 in the high ROM half.
    function automatic logic [3:0] rom_decode(input logic [3:0] latch, input logic kernal);
        return {latch[3:2] & ~{2{kernal}}, latch[1:0]};
    endfunction

endpackage

// File: rtl/c16_bus_strobe.sv
// c16_bus_strobe: captures the shared bus every CLK28 and emits one write strobe per CPU cycle
module c16_bus_strobe
    import c16_mem_banker_pkg::*;
(
    input  logic        CLK28,
    input  logic        sreset,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        rw,
    input  logic        mux,
    output logic        wr_stb,
    output logic [15:0] addr_q,
    output logic [7:0]  data_q
);

    bus_cap_t cap_q;
    logic     rw_q;
    logic     mux_q;

    always_ff @(posedge CLK28) begin
        if (sreset) begin
            cap_q <= '0;
            rw_q  <= 1'b1;
            mux_q <= 1'b0;
        end else begin
            cap_q <= {addr, data_in};
            rw_q  <= rw;
            mux_q <= mux;
        end
    end

    // Rising mux ends the CPU phase; the address/data latched a cycle earlier are the stable ones.
    assign wr_stb = mux & ~mux_q & ~rw_q;
    assign addr_q = cap_q.addr;
    assign data_q = cap_q.data;

endmodule

// File: rtl/c16_mem_banker.sv
// c16_mem_banker: ROM-select latch and RAM expansion bank register for the C16 motherboard
module c16_mem_banker
    import c16_mem_banker_pkg::*;
#(
    parameter int          BANK_BITS   = 2,
    parameter int          EXP_WINDOW  = 0,
    parameter logic [15:0] EXP_ADDR    = EXP_ADDR_DEF,
    parameter logic [11:0] ROMSEL_BASE = ROMSEL_BASE_DEF,
    parameter logic [7:0]  KERNAL_PAGE = KERNAL_PAGE_DEF
) (
    input  logic        CLK28,
    input  logic        sreset,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        rw,
    input  logic        mux,
    input  logic        aec,
    output logic [3:0]  rom_sel,
    output logic [(BANK_BITS > 0 ? BANK_BITS : 1)-1:0] ram_bank,
    output logic [7:0]  exp_data,
    output logic        bank_changed
);

    localparam int BW = BANK_BITS > 0 ? BANK_BITS : 1;
    localparam logic HAS_EXP = BANK_BITS > 0;

    logic          wr_stb;
    logic [15:0]   addr_q;
    logic [7:0]    data_q;
    logic          rom_wr, exp_wr;
    logic [3:0]    rom_sel_q, rom_sel_d;
    logic [BW-1:0] cpu_bank_q, cpu_bank_d;
    logic          ted_follow_q, ted_follow_d;
    logic          bank_changed_q, bank_changed_d;
    logic [7:0]    readback;
    logic          unused_data;

    c16_bus_strobe u_strobe (
        .CLK28   (CLK28),
        .sreset  (sreset),
        .addr    (addr),
        .data_in (data_in),
        .rw      (rw),
        .mux     (mux),
        .wr_stb  (wr_stb),
        .addr_q  (addr_q),
        .data_q  (data_q)
    );

    assign rom_wr      = wr_stb & (addr_q[15:4] == ROMSEL_BASE);
    assign exp_wr      = wr_stb & (addr_q == EXP_ADDR) & HAS_EXP;
    assign unused_data = ^data_q;

    always_comb begin
        rom_sel_d      = rom_wr ? addr_q[3:0] : rom_sel_q;
        cpu_bank_d     = exp_wr ? data_q[BW-1:0] : cpu_bank_q;
        ted_follow_d   = exp_wr ? data_q[7] : ted_follow_q;
        bank_changed_d = exp_wr & (cpu_bank_d != cpu_bank_q);
    end

    always_ff @(posedge CLK28) begin
        if (sreset) begin
            rom_sel_q      <= '0;
            cpu_bank_q     <= '0;
            ted_follow_q   <= 1'b0;
            bank_changed_q <= 1'b0;
        end else begin
            rom_sel_q      <= rom_sel_d;
            cpu_bank_q     <= cpu_bank_d;
            ted_follow_q   <= ted_follow_d;
            bank_changed_q <= bank_changed_d;
        end
    end

    // Bits without a register behind them read back as 1 on the wired-AND data bus.
    always_comb begin
        readback         = {ted_follow_q, 7'h7F};
        readback[BW-1:0] = cpu_bank_q;
    end

    assign rom_sel      = rom_decode(rom_sel_q, addr[15:8] == KERNAL_PAGE);
    assign exp_data     = (rw & (addr == EXP_ADDR) & HAS_EXP) ? readback : 8'hFF;
    assign ram_bank     = (!HAS_EXP || (!aec && !ted_follow_q) ||
                           (EXP_WINDOW == 1 && addr[15:12] == 4'h0)) ? '0 : cpu_bank_q;
    assign bank_changed = bank_changed_q;

endmodule

// File: tb/tb_c16_mem_banker.sv
// tb_c16_mem_banker: table, directed and random transaction checks for three builds of the banker
module tb_c16_mem_banker;

    logic        CLK28 = 1'b0;
    logic        sreset = 1'b1;
    logic [15:0] addr = '0;
    logic [7:0]  data_in = '0;
    logic        rw = 1'b1;
    logic        mux = 1'b0;
    logic        aec = 1'b1;

    logic [3:0] rom_m, rom_w, rom_n;
    logic [1:0] ram_m, ram_w;
    logic [0:0] ram_n;
    logic [7:0] dat_m, dat_w, dat_n;
    logic       bc_m, bc_w, bc_n;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] m_rom;
    logic [1:0] m_bank;
    logic       m_tf;

    typedef struct {
        logic [15:0] a;
        logic        r;
        logic        ag;
        logic [3:0]  rom;
        logic [1:0]  ram;
        logic [1:0]  ram_w;
        logic [7:0]  dat;
    } vec_t;

    vec_t tbl[7];

    always #5 CLK28 = ~CLK28;

    c16_mem_banker u_main (
        .CLK28(CLK28), .sreset(sreset), .addr(addr), .data_in(data_in), .rw(rw), .mux(mux), .aec(aec),
        .rom_sel(rom_m), .ram_bank(ram_m), .exp_data(dat_m), .bank_changed(bc_m)
    );

    c16_mem_banker #(.EXP_WINDOW(1)) u_win (
        .CLK28(CLK28), .sreset(sreset), .addr(addr), .data_in(data_in), .rw(rw), .mux(mux), .aec(aec),
        .rom_sel(rom_w), .ram_bank(ram_w), .exp_data(dat_w), .bank_changed(bc_w)
    );

    c16_mem_banker #(.BANK_BITS(0)) u_nb (
        .CLK28(CLK28), .sreset(sreset), .addr(addr), .data_in(data_in), .rw(rw), .mux(mux), .aec(aec),
        .rom_sel(rom_n), .ram_bank(ram_n), .exp_data(dat_n), .bank_changed(bc_n)
    );

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (addr=%h rw=%b aec=%b)", name, act, exp, addr, rw, aec);
        end
    endtask

    task automatic tick();
        @(posedge CLK28);
        #1;
    endtask

    function automatic logic model_write(input logic [15:0] a, input logic [7:0] d);
        logic p;
        p = 1'b0;
        if (a[15:4] == 12'hFDD) m_rom = a[3:0];
        if (a == 16'hFD16) begin
            p = d[1:0] != m_bank;
            m_bank = d[1:0];
            m_tf = d[7];
        end
        return p;
    endfunction

    task automatic model_reset();
        m_rom = '0;
        m_bank = '0;
        m_tf = 1'b0;
    endtask

    task automatic check(input logic [15:0] a, input logic r, input logic ag);
        logic [3:0] e_rom;
        logic [1:0] e_ram;
        logic [7:0] e_dat;
        addr = a;
        rw = r;
        mux = 1'b0;
        aec = ag;
        #1;
        e_rom = {(a[15:8] == 8'hFC) ? 2'b00 : m_rom[3:2], m_rom[1:0]};
        e_ram = (!ag && !m_tf) ? 2'd0 : m_bank;
        e_dat = (r && a == 16'hFD16) ? {m_tf, 5'h1F, m_bank} : 8'hFF;
        cmp("rom_sel", rom_m, e_rom);
        cmp("ram_bank", ram_m, e_ram);
        cmp("exp_data", dat_m, e_dat);
        cmp("ram_bank_win", ram_w, (a < 16'h1000) ? 2'd0 : e_ram);
        cmp("rom_sel_nobank", rom_n, e_rom);
        cmp("exp_data_nobank", dat_n, 8'hFF);
        cmp("ram_bank_nobank", ram_n, 8'h00);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        int pm, pw, pn;
        logic ep;
        addr = a;
        data_in = d;
        rw = 1'b0;
        mux = 1'b0;
        tick();
        mux = 1'b1;
        tick();
        mux = 1'b0;
        rw = 1'b1;
        pm = bc_m; pw = bc_w; pn = bc_n;
        tick();
        pm += bc_m; pw += bc_w; pn += bc_n;
        ep = model_write(a, d);
        cmp("pulses", 8'(pm), 8'(ep));
        cmp("pulses_win", 8'(pw), 8'(ep));
        cmp("pulses_nobank", 8'(pn), 8'h00);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 16'hFD16;
            1: return {8'hFC, 8'($urandom)};
            2: return {4'h0, 12'($urandom)};
            3: return 16'h1000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int p;
        tbl[0] = '{16'hFC10, 1'b1, 1'b1, 4'h2, 2'd3, 2'd3, 8'hFF};
        tbl[1] = '{16'h8000, 1'b1, 1'b1, 4'h6, 2'd3, 2'd3, 8'hFF};
        tbl[2] = '{16'hFD16, 1'b1, 1'b1, 4'h6, 2'd3, 2'd3, 8'hFF};
        tbl[3] = '{16'hFD16, 1'b0, 1'b1, 4'h6, 2'd3, 2'd3, 8'hFF};
        tbl[4] = '{16'h0FFF, 1'b1, 1'b0, 4'h6, 2'd3, 2'd0, 8'hFF};
        tbl[5] = '{16'h1000, 1'b1, 1'b0, 4'h6, 2'd3, 2'd3, 8'hFF};
        tbl[6] = '{16'hFCFF, 1'b1, 1'b0, 4'h2, 2'd3, 2'd3, 8'hFF};

        model_reset();
        repeat (3) tick();
        sreset = 1'b0;
        tick();
        check(16'h8000, 1'b1, 1'b1);
        cmp("bank_changed_reset", bc_m, 8'h00);

        bus_write(16'hFDD6, 8'h00);
        check(16'hFC10, 1'b1, 1'b1);
        check(16'h8000, 1'b1, 1'b1);
        bus_write(16'hFD16, 8'h83);

        for (int i = 0; i < 7; i++) begin
            addr = tbl[i].a;
            rw = tbl[i].r;
            aec = tbl[i].ag;
            #1;
            cmp("tbl_rom_sel", rom_m, tbl[i].rom);
            cmp("tbl_ram_bank", ram_m, tbl[i].ram);
            cmp("tbl_ram_bank_win", ram_w, tbl[i].ram_w);
            cmp("tbl_exp_data", dat_m, tbl[i].dat);
            cmp("tbl_exp_data_nobank", dat_n, 8'hFF);
        end

        bus_write(16'hFD16, 8'h03);
        bus_write(16'hFD16, 8'h03);
        check(16'h8000, 1'b1, 1'b0);
        check(16'h8000, 1'b1, 1'b1);
        check(16'hFD16, 1'b1, 1'b1);
        bus_write(16'hFD16, 8'h02);
        bus_write(16'hFD16, 8'h02);
        check(16'h0FFF, 1'b1, 1'b1);
        check(16'h1000, 1'b1, 1'b1);

        // mux held high: only the first edge writes, later data must be ignored
        addr = 16'hFD16; data_in = 8'h01; rw = 1'b0; mux = 1'b0;
        tick();
        mux = 1'b1;
        tick();
        data_in = 8'h00;
        p = bc_m;
        repeat (9) begin
            tick();
            p += bc_m;
        end
        void'(model_write(16'hFD16, 8'h01));
        cmp("hold_pulses", 8'(p), 8'h01);
        mux = 1'b0; rw = 1'b1;
        tick();
        check(16'hFD16, 1'b1, 1'b1);

        // read cycle across a mux edge
        addr = 16'hFD16; data_in = 8'h03; rw = 1'b1; mux = 1'b0;
        tick();
        mux = 1'b1;
        tick();
        p = bc_m;
        mux = 1'b0;
        tick();
        p += bc_m;
        cmp("read_pulses", 8'(p), 8'h00);
        check(16'hFD16, 1'b1, 1'b1);

        // reset coinciding with the strobe
        addr = 16'hFD16; data_in = 8'h02; rw = 1'b0; mux = 1'b0;
        tick();
        mux = 1'b1;
        sreset = 1'b1;
        tick();
        sreset = 1'b0;
        mux = 1'b0;
        rw = 1'b1;
        cmp("reset_strobe_pulse", bc_m, 8'h00);
        model_reset();
        check(16'hFD16, 1'b1, 1'b1);
        tick();
        cmp("reset_strobe_pulse_late", bc_m, 8'h00);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0: bus_write(16'hFD16, 8'($urandom));
                1: bus_write({12'hFDD, 4'($urandom)}, 8'($urandom));
                2: bus_write(16'($urandom), 8'($urandom));
                default: check(pick_addr(), 1'($urandom), 1'($urandom));
            endcase
            check(pick_addr(), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
